// File: rtl/rdp_pkg.sv
// Shared definitions for the return-data processor: control encodings, FSM states, FIFO entry.
package rdp_pkg;

    localparam logic [1:0] CNTL_MOM     = 2'b00;
    localparam logic [1:0] CNTL_SOM     = 2'b01;
    localparam logic [1:0] CNTL_EOM     = 2'b10;
    localparam logic [1:0] CNTL_SOM_EOM = 2'b11;

    localparam int RDP_ADDR_W = 24;
    localparam int RDP_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } rdp_state_t;

    typedef struct packed {
        logic [RDP_ADDR_W-1:0] addr;
        logic [RDP_DATA_W-1:0] data;
        logic                  last;
    } rdp_fifo_entry_t;

    // Bit 0 marks start of message, bit 1 marks end of message.
    function automatic logic cntl_is_som(input logic [1:0] cntl);
        return cntl[0];
    endfunction

    function automatic logic cntl_is_eom(input logic [1:0] cntl);
        return cntl[1];
    endfunction

endpackage

// File: rtl/rdp_fifo.sv
// Synchronous FIFO with a registered head stage: DEPTH storage entries plus the output register.
module rdp_fifo #(
    parameter int WIDTH = 57,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_poweron,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             head_load;
    logic             mem_rd;
    logic             mem_wr;

    assign full      = (count == (PTR_W+1)'(DEPTH));
    assign head_load = !out_valid || out_ready;
    assign mem_rd    = head_load && (count != '0);
    // With storage empty and the head free, a push bypasses straight into the head.
    assign mem_wr    = push && !(head_load && (count == '0));

    always_ff @(posedge clk) begin
        if (!reset_poweron) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            if (head_load) begin
                if (mem_rd) begin
                    out_data  <= mem[rd_ptr];
                    out_valid <= 1'b1;
                    rd_ptr    <= rd_ptr + 1'b1;
                end else if (push) begin
                    out_data  <= push_data;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end
            if (mem_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            count <= count + (PTR_W+1)'(mem_wr) - (PTR_W+1)'(mem_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/return_data_proc.sv
// Return-data processor: maps tagged result packets to sequential DRAM write words.
// Optional per-packet word counter enabled by defining RDP_WORD_COUNT_EN.
module return_data_proc
    import rdp_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int TAG_W      = 4,
    parameter int ADDR_W     = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_poweron,
    input  logic              stuc__rdp__valid,
    input  logic [1:0]        stuc__rdp__cntl,
    output logic              rdp__stuc__ready,
    input  logic [TAG_W-1:0]  stuc__rdp__tag,
    input  logic [DATA_W-1:0] stuc__rdp__data,
    input  logic              wud__rdp__valid,
    input  logic [TAG_W-1:0]  wud__rdp__tag,
    input  logic [ADDR_W-1:0] wud__rdp__addr,
    output logic              rdp__dma__valid,
    input  logic              dma__rdp__ready,
    output logic [ADDR_W-1:0] rdp__dma__addr,
    output logic [DATA_W-1:0] rdp__dma__data,
    output logic              rdp__dma__last,
    output logic              rdp__wud__complete,
    output logic [TAG_W-1:0]  rdp__wud__tag,
    output logic [15:0]       rdp__wud__len,
    output logic              rdp__sys__error,
    output logic [1:0]        dbg_state
);
    localparam int ENTRIES = 1 << TAG_W;
    localparam int FW      = ADDR_W + DATA_W + 1;

    rdp_state_t        state;
    logic [ENTRIES-1:0] tbl_valid;
    logic [ADDR_W-1:0] tbl_addr [ENTRIES];
    logic [ADDR_W-1:0] cur_addr;
    logic [TAG_W-1:0]  cur_tag;
    logic              keep_entry;
    logic              fifo_full;
    logic              accept, som, eom, wud_hit;
    logic              lookup_valid;
    logic [ADDR_W-1:0] lookup_addr;
    logic              push, push_last;
    logic [ADDR_W-1:0] push_addr;
    logic [FW-1:0]     head;
    logic [15:0]       len_som, len_pass, len_old;

    assign dbg_state        = state;
    assign rdp__stuc__ready = reset_poweron && (!fifo_full || state == ST_DROP);
    assign accept           = stuc__rdp__valid && rdp__stuc__ready;
    assign som              = cntl_is_som(stuc__rdp__cntl);
    assign eom              = cntl_is_eom(stuc__rdp__cntl);
    // A table write in the same cycle as the SOM lookup is forwarded.
    assign wud_hit          = wud__rdp__valid && (wud__rdp__tag == stuc__rdp__tag);
    assign lookup_valid     = wud_hit || tbl_valid[stuc__rdp__tag];
    assign lookup_addr      = wud_hit ? wud__rdp__addr : tbl_addr[stuc__rdp__tag];

`ifdef RDP_WORD_COUNT_EN
    logic [15:0] word_cnt;
    assign len_som  = 16'd1;
    assign len_old  = word_cnt;
    assign len_pass = (word_cnt == 16'hFFFF) ? word_cnt : word_cnt + 16'd1;

    always_ff @(posedge clk) begin
        if (!reset_poweron) begin
            word_cnt <= '0;
        end else if (accept) begin
            if (som) begin
                word_cnt <= 16'd1;
            end else if (state == ST_PASS) begin
                word_cnt <= len_pass;
            end
        end
    end
`else
    assign len_som  = 16'd0;
    assign len_old  = 16'd0;
    assign len_pass = 16'd0;
`endif

    always_comb begin
        push      = 1'b0;
        push_addr = cur_addr;
        push_last = eom;
        if (accept) begin
            if (som) begin
                push      = lookup_valid;
                push_addr = lookup_addr;
            end else begin
                push = (state == ST_PASS);
            end
        end
    end

    rdp_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk          (clk),
        .reset_poweron(reset_poweron),
        .push         (push),
        .push_data    ({push_addr, stuc__rdp__data, push_last}),
        .full         (fifo_full),
        .out_valid    (rdp__dma__valid),
        .out_data     (head),
        .out_ready    (dma__rdp__ready)
    );

    assign rdp__dma__addr = head[FW-1 -: ADDR_W];
    assign rdp__dma__data = head[DATA_W:1];
    assign rdp__dma__last = head[0];

    always_ff @(posedge clk) begin
        if (!reset_poweron) begin
            state              <= ST_IDLE;
            tbl_valid          <= '0;
            cur_addr           <= '0;
            cur_tag            <= '0;
            keep_entry         <= 1'b0;
            rdp__sys__error    <= 1'b0;
            rdp__wud__complete <= 1'b0;
            rdp__wud__tag      <= '0;
            rdp__wud__len      <= '0;
        end else begin
            rdp__wud__complete <= 1'b0;
            if (accept) begin
                if (som) begin
                    // SOM while a packet is open: close the old one with an error.
                    if (state == ST_PASS) begin
                        rdp__sys__error    <= 1'b1;
                        rdp__wud__complete <= 1'b1;
                        rdp__wud__tag      <= cur_tag;
                        rdp__wud__len      <= len_old;
                        if (!keep_entry) tbl_valid[cur_tag] <= 1'b0;
                    end
                    cur_tag    <= stuc__rdp__tag;
                    keep_entry <= 1'b0;
                    cur_addr   <= lookup_addr + 1'b1;
                    if (!lookup_valid) begin
                        state           <= ST_DROP;
                        rdp__sys__error <= 1'b1;
                    end else if (eom) begin
                        state              <= ST_IDLE;
                        rdp__wud__complete <= 1'b1;
                        rdp__wud__tag      <= stuc__rdp__tag;
                        rdp__wud__len      <= len_som;
                        tbl_valid[stuc__rdp__tag] <= 1'b0;
                    end else begin
                        state <= ST_PASS;
                    end
                end else begin
                    case (state)
                        ST_IDLE: rdp__sys__error <= 1'b1;
                        ST_PASS: begin
                            cur_addr <= cur_addr + 1'b1;
                            if (eom) begin
                                state              <= ST_IDLE;
                                rdp__wud__complete <= 1'b1;
                                rdp__wud__tag      <= cur_tag;
                                rdp__wud__len      <= len_pass;
                                if (!keep_entry) tbl_valid[cur_tag] <= 1'b0;
                            end
                        end
                        ST_DROP: if (eom) state <= ST_IDLE;
                        default: state <= ST_IDLE;
                    endcase
                end
            end
            // A rewrite of the open packet's tag keeps the entry alive past its EOM.
            if (state == ST_PASS && wud__rdp__valid && wud__rdp__tag == cur_tag && !(accept && som))
                keep_entry <= 1'b1;
            if (wud__rdp__valid) tbl_valid[wud__rdp__tag] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wud__rdp__valid) begin
            tbl_addr[wud__rdp__tag] <= wud__rdp__addr;
        end
    end

endmodule
